// File: rtl/t07_maze_pkg.sv
// Shared types and constants for the maze-navigation core.
package t07_maze_pkg;

  // One-hot button vector: {BACK,LEFT,DOWN,RIGHT,UP,SELECT}
  typedef logic [5:0] btn_t;

  // One-hot direction, same encoding as the button vector
  typedef btn_t dir_t;

  localparam btn_t NO_PRESS = 6'b000000;
  localparam btn_t SELECT   = 6'b000001;
  localparam btn_t UP       = 6'b000010;
  localparam btn_t RIGHT    = 6'b000100;
  localparam btn_t DOWN     = 6'b001000;
  localparam btn_t LEFT     = 6'b010000;
  localparam btn_t BACK     = 6'b100000;

  // Buttons that request a movement on the grid
  localparam btn_t MOVE_MASK = 6'b011110;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PLAY    = 3'd2,
    ST_CLEARED = 3'd3,
    ST_OVER    = 3'd4,
    ST_WIN     = 3'd5
  } state_t;

  // True when exactly one button bit is set
  function automatic logic is_onehot6(input btn_t b);
    return (b != 6'd0) && ((b & (b - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/t07_maze_move_check.sv
// Combinational move legality: next cell, bounds and wall lookup in one place.
module t07_maze_move_check
  import t07_maze_pkg::*;
#(
  parameter int GRID_W  = 6,
  parameter int GRID_H  = 6,
  parameter int COORD_W = 3
) (
  input  logic [COORD_W-1:0]             i_pos_x,
  input  logic [COORD_W-1:0]             i_pos_y,
  input  dir_t                           i_dir,
  input  logic [GRID_H*(GRID_W-1)-1:0]   i_wall_v,
  input  logic [(GRID_H-1)*GRID_W-1:0]   i_wall_h,
  output logic [COORD_W-1:0]             o_next_x,
  output logic [COORD_W-1:0]             o_next_y,
  output logic                           o_legal
);

  localparam int VW_N = GRID_H * (GRID_W - 1);
  localparam int HW_N = (GRID_H - 1) * GRID_W;
  localparam int VI_W = (VW_N > 1) ? $clog2(VW_N) : 1;
  localparam int HI_W = (HW_N > 1) ? $clog2(HW_N) : 1;

  // One extra bit so that 0-1 shows up as a large (out-of-range) value
  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(GRID_H);
  localparam logic [COORD_W:0] ONE   = (COORD_W+1)'(1);

  logic [COORD_W:0] w_nx;
  logic [COORD_W:0] w_ny;
  logic             w_is_dir;
  logic             w_inb;
  logic             w_wall;
  logic [VI_W-1:0]  w_vidx;
  logic [HI_W-1:0]  w_hidx;

  // Candidate target cell for the requested direction
  always_comb begin
    w_nx     = {1'b0, i_pos_x};
    w_ny     = {1'b0, i_pos_y};
    w_is_dir = 1'b1;
    case (i_dir)
      UP:      w_ny = {1'b0, i_pos_y} + ONE;
      DOWN:    w_ny = {1'b0, i_pos_y} - ONE;
      RIGHT:   w_nx = {1'b0, i_pos_x} + ONE;
      LEFT:    w_nx = {1'b0, i_pos_x} - ONE;
      default: w_is_dir = 1'b0;
    endcase
  end

  // Bounds check, then look up the wall bit crossed by the move
  always_comb begin
    w_inb  = w_is_dir && (w_nx < W_LIM) && (w_ny < H_LIM);
    w_vidx = '0;
    w_hidx = '0;
    w_wall = 1'b0;
    if (w_inb) begin
      case (i_dir)
        RIGHT: begin
          w_vidx = VI_W'(int'(i_pos_y) * (GRID_W - 1) + int'(i_pos_x));
          w_wall = i_wall_v[w_vidx];
        end
        LEFT: begin
          w_vidx = VI_W'(int'(i_pos_y) * (GRID_W - 1) + int'(i_pos_x) - 1);
          w_wall = i_wall_v[w_vidx];
        end
        UP: begin
          w_hidx = HI_W'(int'(i_pos_y) * GRID_W + int'(i_pos_x));
          w_wall = i_wall_h[w_hidx];
        end
        DOWN: begin
          w_hidx = HI_W'((int'(i_pos_y) - 1) * GRID_W + int'(i_pos_x));
          w_wall = i_wall_h[w_hidx];
        end
        default: w_wall = 1'b0;
      endcase
    end else begin
      w_wall = 1'b0;
    end
  end

  assign o_next_x = w_nx[COORD_W-1:0];
  assign o_next_y = w_ny[COORD_W-1:0];
  assign o_legal  = w_inb & ~w_wall;

endmodule

// File: rtl/t07_maze_nav.sv
// Maze game core: player position, lives, move count, levels and game FSM.
module t07_maze_nav
  import t07_maze_pkg::*;
#(
  parameter int GRID_W     = 6,
  parameter int GRID_H     = 6,
  parameter int COORD_W    = 3,
  parameter int NUM_LEVELS = 4,
  parameter int MAX_LIVES  = 3,
  parameter int MOVE_W     = 8
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           strobe,
  input  logic [5:0]                     button,
  input  logic [COORD_W-1:0]             start_x,
  input  logic [COORD_W-1:0]             start_y,
  input  logic [COORD_W-1:0]             dest_x,
  input  logic [COORD_W-1:0]             dest_y,
  input  logic [GRID_H*(GRID_W-1)-1:0]   wall_v,
  input  logic [(GRID_H-1)*GRID_W-1:0]   wall_h,
  output logic [3:0]                     level,
  output logic [COORD_W-1:0]             pos_x,
  output logic [COORD_W-1:0]             pos_y,
  output logic [2:0]                     lives,
  output logic [MOVE_W-1:0]              moves,
  output logic                           error,
  output logic                           maze_clear,
  output logic [2:0]                     state_o
);

  localparam logic [3:0]        LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [2:0]        FULL_LIVES = 3'(MAX_LIVES);
  localparam logic [MOVE_W-1:0] MOVE_ONE   = MOVE_W'(1);

  state_t              r_state;
  logic [3:0]          r_level;
  logic [COORD_W-1:0]  r_pos_x;
  logic [COORD_W-1:0]  r_pos_y;
  logic [2:0]          r_lives;
  logic [MOVE_W-1:0]   r_moves;
  logic                r_error;
  logic                r_clear;

  logic [COORD_W-1:0]  w_next_x;
  logic [COORD_W-1:0]  w_next_y;
  logic                w_legal;
  logic                w_press;
  logic                w_is_move;
  logic                w_at_dest;
  logic                w_next_dest;

  t07_maze_move_check #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .COORD_W (COORD_W)
  ) u_move_check (
    .i_pos_x  (r_pos_x),
    .i_pos_y  (r_pos_y),
    .i_dir    (button),
    .i_wall_v (wall_v),
    .i_wall_h (wall_h),
    .o_next_x (w_next_x),
    .o_next_y (w_next_y),
    .o_legal  (w_legal)
  );

  // Only a strobed, exactly one-hot button counts as a press
  assign w_press     = strobe && is_onehot6(button);
  assign w_is_move   = |(button & MOVE_MASK);
  assign w_at_dest   = (r_pos_x == dest_x) && (r_pos_y == dest_y);
  assign w_next_dest = (w_next_x == dest_x) && (w_next_y == dest_y);

  // Game FSM with all outputs held in registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_level <= 4'd0;
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_lives <= FULL_LIVES;
      r_moves <= '0;
      r_error <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_error <= 1'b0;
      r_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_press && (button == SELECT)) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_pos_x <= start_x;
          r_pos_y <= start_y;
          r_moves <= '0;
          r_state <= ST_PLAY;
        end
        ST_PLAY: begin
          // Start == dest: the level is already solved on entry
          if (w_at_dest) begin
            r_clear <= 1'b1;
            r_state <= ST_CLEARED;
          end else if (w_press) begin
            if (button == BACK) begin
              r_state <= ST_IDLE;
            end else if (w_is_move) begin
              if (w_legal) begin
                r_pos_x <= w_next_x;
                r_pos_y <= w_next_y;
                if (r_moves != '1) begin
                  r_moves <= r_moves + MOVE_ONE;
                end
                if (w_next_dest) begin
                  r_clear <= 1'b1;
                  r_state <= ST_CLEARED;
                end
              end else begin
                r_error <= 1'b1;
                if (r_lives <= 3'd1) begin
                  r_lives <= 3'd0;
                  r_state <= ST_OVER;
                end else begin
                  r_lives <= r_lives - 3'd1;
                end
              end
            end
          end
        end
        ST_CLEARED: begin
          if (w_press && (button == SELECT)) begin
            if (r_level == LAST_LEVEL) begin
              r_state <= ST_WIN;
            end else begin
              r_level <= r_level + 4'd1;
              r_state <= ST_LOAD;
            end
          end else if (w_press && (button == BACK)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_OVER, ST_WIN: begin
          if (w_press && (button == SELECT)) begin
            r_lives <= FULL_LIVES;
            r_level <= 4'd0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign level      = r_level;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign lives      = r_lives;
  assign moves      = r_moves;
  assign error      = r_error;
  assign maze_clear = r_clear;
  assign state_o    = r_state;

endmodule

// File: tb/tb_t07_maze_nav.sv
// Directed, table-driven bench for the maze navigation core.
module tb_t07_maze_nav;
  import t07_maze_pkg::*;

  localparam int GW = 6;
  localparam int GH = 6;
  localparam int CW = 3;
  localparam int NL = 2;
  localparam int ML = 3;
  localparam int MW = 8;

  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_SEL  = 6'b000001;
  localparam logic [5:0] B_UP   = 6'b000010;
  localparam logic [5:0] B_RT   = 6'b000100;
  localparam logic [5:0] B_DN   = 6'b001000;
  localparam logic [5:0] B_LT   = 6'b010000;
  localparam logic [5:0] B_BK   = 6'b100000;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_PLAY = 2;
  localparam int S_CLR  = 3;
  localparam int S_OVER = 4;
  localparam int S_WIN  = 5;

  logic                    clk;
  logic                    nrst;
  logic                    strobe;
  logic [5:0]              button;
  logic [CW-1:0]           start_x, start_y, dest_x, dest_y;
  logic [GH*(GW-1)-1:0]    wall_v;
  logic [(GH-1)*GW-1:0]    wall_h;
  logic [3:0]              level;
  logic [CW-1:0]           pos_x, pos_y;
  logic [2:0]              lives;
  logic [MW-1:0]           moves;
  logic                    error;
  logic                    maze_clear;
  logic [2:0]              state_o;

  int n_pass;
  int n_total;

  typedef struct {
    logic       stb;
    logic [5:0] btn;
    int         x, y, lv, mv, er, cl, st, lvl;
  } vec_t;

  vec_t vq[$];

  t07_maze_nav #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(CW),
    .NUM_LEVELS(NL), .MAX_LIVES(ML), .MOVE_W(MW)
  ) dut (
    .clk(clk), .nrst(nrst), .strobe(strobe), .button(button),
    .start_x(start_x), .start_y(start_y), .dest_x(dest_x), .dest_y(dest_y),
    .wall_v(wall_v), .wall_h(wall_h),
    .level(level), .pos_x(pos_x), .pos_y(pos_y), .lives(lives),
    .moves(moves), .error(error), .maze_clear(maze_clear), .state_o(state_o)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_all(input string tag, input int x, input int y, input int lv,
                         input int mv, input int er, input int cl, input int st,
                         input int lvl);
    chk({tag, " pos_x"},      32'(pos_x),      x);
    chk({tag, " pos_y"},      32'(pos_y),      y);
    chk({tag, " lives"},      32'(lives),      lv);
    chk({tag, " moves"},      32'(moves),      mv);
    chk({tag, " error"},      32'(error),      er);
    chk({tag, " maze_clear"}, 32'(maze_clear), cl);
    chk({tag, " state"},      32'(state_o),    st);
    chk({tag, " level"},      32'(level),      lvl);
  endtask

  task automatic add(input logic s, input logic [5:0] b, input int x, input int y,
                     input int lv, input int mv, input int er, input int cl,
                     input int st, input int lvl);
    vec_t v;
    v.stb = s; v.btn = b; v.x = x; v.y = y; v.lv = lv; v.mv = mv;
    v.er = er; v.cl = cl; v.st = st; v.lvl = lvl;
    vq.push_back(v);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    nrst    = 1'b0;
    strobe  = 1'b0;
    button  = B_NONE;
    start_x = 3'd2; start_y = 3'd4;
    dest_x  = 3'd4; dest_y  = 3'd5;
    wall_v  = '0;
    wall_h  = '0;
    wall_v[4*(GW-1)+3] = 1'b1;   // wall between (3,4) and (4,4)

    //  stb btn    x  y  lv mv er cl st      lvl
    add(1, B_SEL,  0, 0, 3, 0, 0, 0, S_LOAD, 0);  // 0  IDLE -> LOAD
    add(0, B_NONE, 2, 4, 3, 0, 0, 0, S_PLAY, 0);  // 1  start latched
    add(1, B_RT,   3, 4, 3, 1, 0, 0, S_PLAY, 0);
    add(1, B_UP,   3, 5, 3, 2, 0, 0, S_PLAY, 0);
    add(1, B_RT,   4, 5, 3, 3, 0, 1, S_CLR,  0);  // 4  reach dest
    add(0, B_NONE, 4, 5, 3, 3, 0, 0, S_CLR,  0);  // 5  clear is one pulse
    add(1, B_LT,   4, 5, 3, 3, 0, 0, S_CLR,  0);  // 6  moves ignored here
    add(1, B_SEL,  4, 5, 3, 3, 0, 0, S_LOAD, 1);  // 7  next level
    add(0, B_NONE, 2, 4, 3, 0, 0, 0, S_PLAY, 1);
    add(1, B_RT,   3, 4, 3, 1, 0, 0, S_PLAY, 1);
    add(1, 6'b000110, 3, 4, 3, 1, 0, 0, S_PLAY, 1); // 10 multi-hot ignored
    add(0, B_RT,   3, 4, 3, 1, 0, 0, S_PLAY, 1);  // 11 no strobe
    add(1, B_UP,   3, 5, 3, 2, 0, 0, S_PLAY, 1);
    add(1, B_RT,   4, 5, 3, 3, 0, 1, S_CLR,  1);
    add(1, B_SEL,  4, 5, 3, 3, 0, 0, S_WIN,  1);  // 14 last level -> WIN
    add(1, B_UP,   4, 5, 3, 3, 0, 0, S_WIN,  1);
    add(1, B_SEL,  4, 5, 3, 3, 0, 0, S_IDLE, 0);  // 16 restart
    add(1, B_UP,   4, 5, 3, 3, 0, 0, S_IDLE, 0);
    add(1, B_SEL,  4, 5, 3, 3, 0, 0, S_LOAD, 0);
    add(0, B_NONE, 2, 4, 3, 0, 0, 0, S_PLAY, 0);
    add(1, B_RT,   3, 4, 3, 1, 0, 0, S_PLAY, 0);
    add(1, B_RT,   3, 4, 2, 1, 1, 0, S_PLAY, 0);  // 21 wall hit
    add(0, B_NONE, 3, 4, 2, 1, 0, 0, S_PLAY, 0);  // 22 error one pulse
    add(1, B_UP,   3, 5, 2, 2, 0, 0, S_PLAY, 0);
    add(1, B_UP,   3, 5, 1, 2, 1, 0, S_PLAY, 0);  // 24 top edge
    add(1, B_DN,   3, 4, 1, 3, 0, 0, S_PLAY, 0);
    add(1, B_RT,   3, 4, 0, 3, 1, 0, S_OVER, 0);  // 26 last life
    add(0, B_NONE, 3, 4, 0, 3, 0, 0, S_OVER, 0);
    add(1, B_SEL,  3, 4, 3, 3, 0, 0, S_IDLE, 0);  // 28 OVER -> IDLE
    add(1, B_SEL,  3, 4, 3, 3, 0, 0, S_LOAD, 0);
    add(0, B_NONE, 2, 4, 3, 0, 0, 0, S_PLAY, 0);
    add(1, B_LT,   1, 4, 3, 1, 0, 0, S_PLAY, 0);
    add(1, B_LT,   0, 4, 3, 2, 0, 0, S_PLAY, 0);
    add(1, B_LT,   0, 4, 2, 2, 1, 0, S_PLAY, 0);  // 33 x=0 left edge
    add(1, B_BK,   0, 4, 2, 2, 0, 0, S_IDLE, 0);  // 34 BACK holds lives
    add(1, B_SEL,  0, 4, 2, 2, 0, 0, S_LOAD, 0);
    add(0, B_NONE, 2, 4, 2, 0, 0, 0, S_PLAY, 0);  // 36 lives kept

    // Reset values while nrst is low
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 3, 0, 0, 0, S_IDLE, 0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      strobe = vq[i].stb;
      button = vq[i].btn;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vq[i].x, vq[i].y, vq[i].lv, vq[i].mv,
              vq[i].er, vq[i].cl, vq[i].st, vq[i].lvl);
      strobe = 1'b0;
      button = B_NONE;
    end

    // Reset pulse while a RIGHT strobe is pending in PLAY
    @(negedge clk);
    strobe = 1'b1;
    button = B_RT;
    #2;
    nrst = 1'b0;
    #1;
    chk_all("rst_mid", 0, 0, 3, 0, 0, 0, S_IDLE, 0);
    @(posedge clk);
    #2;
    nrst   = 1'b1;
    strobe = 1'b0;
    button = B_NONE;
    @(posedge clk);
    #1;
    chk_all("rst_after1", 0, 0, 3, 0, 0, 0, S_IDLE, 0);
    @(posedge clk);
    #1;
    chk_all("rst_after2", 0, 0, 3, 0, 0, 0, S_IDLE, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
